// File: rtl/idecode_queue.sv
// idecode_queue: instruction queue that decodes ARM words as they are pushed
// and presents the decoded head entry to the execute stage.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_valid/i_instr/i_pc/o_ready   fetch-side push handshake
//   i_flush             drop all queued entries and any offered word
//   o_valid/i_ready     execute-side pop handshake for the head entry
//   o_class..o_target   decoded fields of the head (all 0 when empty)
//   o_count             current occupancy
module idecode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic [31:0]                i_instr,
    input  logic [PC_W-1:0]            i_pc,
    output logic                       o_ready,
    input  logic                       i_flush,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [2:0]                 o_class,
    output logic [3:0]                 o_cond,
    output logic [3:0]                 o_opcode,
    output logic                       o_set,
    output logic                       o_imm,
    output logic                       o_byte,
    output logic                       o_load,
    output logic                       o_pre,
    output logic                       o_up,
    output logic                       o_wb,
    output logic                       o_acc,
    output logic                       o_link,
    output logic [3:0]                 o_rd,
    output logic [3:0]                 o_rn,
    output logic [3:0]                 o_rm,
    output logic [3:0]                 o_rs,
    output logic [11:0]                o_operand2,
    output logic [PC_W-1:0]            o_target,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [2:0] C_DP    = 3'd0;
    localparam logic [2:0] C_MUL   = 3'd1;
    localparam logic [2:0] C_SWP   = 3'd2;
    localparam logic [2:0] C_LDST  = 3'd3;
    localparam logic [2:0] C_BR    = 3'd4;
    localparam logic [2:0] C_SWI   = 3'd5;
    localparam logic [2:0] C_UNDEF = 3'd7;

    typedef struct packed {
        logic [2:0]      cls;
        logic [3:0]      cond;
        logic [3:0]      opcode;
        logic            set;
        logic            imm;
        logic            byt;
        logic            load;
        logic            pre;
        logic            up;
        logic            wb;
        logic            acc;
        logic            link;
        logic [3:0]      rd;
        logic [3:0]      rn;
        logic [3:0]      rm;
        logic [3:0]      rs;
        logic [11:0]     op2;
        logic [PC_W-1:0] target;
    } dec_t;

    dec_t          mem [DEPTH];
    dec_t          dec;
    dec_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;

    logic               is_mul;
    logic               is_swp;
    logic               is_br;
    logic               is_swi;
    logic               is_ldst;
    logic               is_dp;
    logic signed [31:0] br_off;
    logic [PC_W-1:0]    br_off_pc;

    assign full    = (count == CW'(DEPTH));
    assign o_ready = !full;
    assign o_valid = (count != '0);
    assign o_count = count;
    assign push    = i_valid && !full && !i_flush;
    assign pop     = o_valid && i_ready && !i_flush;

    assign is_mul  = (i_instr[27:22] == 6'b000000) && (i_instr[7:4] == 4'b1001);
    assign is_swp  = (i_instr[27:23] == 5'b00010) && (i_instr[21:20] == 2'b00)
                     && (i_instr[11:4] == 8'b0000_1001);
    assign is_br   = (i_instr[27:25] == 3'b101);
    assign is_swi  = (i_instr[27:24] == 4'b1111);
    assign is_ldst = (i_instr[27:26] == 2'b01);
    assign is_dp   = (i_instr[27:26] == 2'b00);

    // Word offset shifted to bytes; the size cast sign-extends or
    // truncates to the PC width in one step.
    assign br_off    = {{6{i_instr[23]}}, i_instr[23:0], 2'b00};
    assign br_off_pc = PC_W'(br_off);

    always_comb begin
        dec      = '0;
        dec.cond = i_instr[31:28];
        dec.cls  = C_UNDEF;
        // Encodings overlap (MUL/SWP sit inside the DP space), so the
        // order of this chain is the decode priority.
        if (is_mul) begin
            dec.cls = C_MUL;
            dec.acc = i_instr[21];
            dec.set = i_instr[20];
            dec.rd  = i_instr[19:16];
            dec.rn  = i_instr[15:12];
            dec.rs  = i_instr[11:8];
            dec.rm  = i_instr[3:0];
        end else if (is_swp) begin
            dec.cls = C_SWP;
            dec.byt = i_instr[22];
            dec.rn  = i_instr[19:16];
            dec.rd  = i_instr[15:12];
            dec.rm  = i_instr[3:0];
        end else if (is_br) begin
            dec.cls    = C_BR;
            dec.link   = i_instr[24];
            dec.target = i_pc + PC_W'(8) + br_off_pc;
        end else if (is_swi) begin
            dec.cls = C_SWI;
        end else if (is_ldst) begin
            dec.cls  = C_LDST;
            dec.imm  = !i_instr[25];
            dec.pre  = i_instr[24];
            dec.up   = i_instr[23];
            dec.byt  = i_instr[22];
            dec.wb   = i_instr[21];
            dec.load = i_instr[20];
            dec.rn   = i_instr[19:16];
            dec.rd   = i_instr[15:12];
            dec.rm   = i_instr[3:0];
        end else if (is_dp) begin
            dec.cls    = C_DP;
            dec.imm    = i_instr[25];
            dec.opcode = i_instr[24:21];
            // TST/TEQ/CMP/CMN always update flags
            dec.set    = i_instr[20] || (i_instr[24:23] == 2'b10);
            dec.rn     = i_instr[19:16];
            dec.rd     = i_instr[15:12];
            dec.rm     = i_instr[3:0];
        end
        if (dec.cls != C_UNDEF) begin
            dec.op2 = i_instr[11:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Payload needs no reset: it is only visible while o_valid is set.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    assign head = o_valid ? mem[rd_ptr] : '0;

    assign o_class    = head.cls;
    assign o_cond     = head.cond;
    assign o_opcode   = head.opcode;
    assign o_set      = head.set;
    assign o_imm      = head.imm;
    assign o_byte     = head.byt;
    assign o_load     = head.load;
    assign o_pre      = head.pre;
    assign o_up       = head.up;
    assign o_wb       = head.wb;
    assign o_acc      = head.acc;
    assign o_link     = head.link;
    assign o_rd       = head.rd;
    assign o_rn       = head.rn;
    assign o_rm       = head.rm;
    assign o_rs       = head.rs;
    assign o_operand2 = head.op2;
    assign o_target   = head.target;

endmodule
